// File: rtl/spine_pkg.sv
// Shared constants and link state encoding for the spine egress path.
package spine_pkg;

   localparam int DWIDTH_DEF = 16;
   localparam int AWIDTH_DEF = 6;
   localparam int DEST_MSB   = DWIDTH_DEF - 1;
   localparam int DEST_LSB   = DWIDTH_DEF - AWIDTH_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      STALL = 2'd2
   } link_state_t;

endpackage

// File: rtl/spine_sync_fifo.sv
// First-word-fall-through FIFO: storage, wrapping pointers, occupancy count.
module spine_sync_fifo #(
   parameter int DWIDTH = 16,
   parameter int DEPTH  = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DWIDTH-1:0] wr_data,
   output logic [DWIDTH-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count
);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/spine_egress_buffer.sv
// Spine egress buffer: FIFO, drop counter, link FSM, stall watchdog.
// Optional parity output enabled by SPINE_EGRESS_PARITY_EN.
module spine_egress_buffer
   import spine_pkg::*;
#(
   parameter int DWIDTH      = DWIDTH_DEF,
   parameter int AWIDTH      = AWIDTH_DEF,
   parameter int DEPTH       = 8,
   parameter int STALL_LIMIT = 64,
   localparam int CW         = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              in_valid,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AWIDTH-1:0] out_dest_addr,
   output logic              out_parity,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic [CW-1:0]     fifo_count,
   output logic [15:0]       drop_count,
   output logic              stall_timeout
);

   localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

   logic        push;
   logic        pop;
   logic        drop;
   logic        last_out;
   logic [15:0] stall_cnt;
   link_state_t state;

   assign pop      = out_valid && out_ready;
   assign push     = in_valid && (!fifo_full || pop);
   assign drop     = in_valid && fifo_full && !pop;
   assign last_out = pop && !push && (fifo_count == CW'(1));

   spine_sync_fifo #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data (in_data),
      .rd_data (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign out_valid     = !fifo_empty;
   assign out_dest_addr = out_data[DWIDTH-1 -: AWIDTH];

   always_ff @(posedge clk) begin
      if (reset)
         drop_count <= '0;
      else if (drop && drop_count != 16'hFFFF)
         drop_count <= drop_count + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:
               if (push) state <= SEND;
            SEND:
               if (last_out) state <= IDLE;
               else if (out_valid && !out_ready) state <= STALL;
            STALL:
               if (pop) state <= last_out ? IDLE : SEND;
            default:
               state <= IDLE;
         endcase
      end
   end

   // Watchdog only runs while the FSM has registered a stall.
   always_ff @(posedge clk) begin
      if (reset || pop)
         stall_cnt <= '0;
      else if (state == STALL && !out_ready && stall_cnt != LIMIT)
         stall_cnt <= stall_cnt + 16'd1;
   end

   assign stall_timeout = (stall_cnt == LIMIT);

`ifdef SPINE_EGRESS_PARITY_EN
   assign out_parity = out_valid ? ^out_data : 1'b0;
`else
   assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_spine_egress_buffer.sv
// Directed bench for spine_egress_buffer (DEPTH=8, STALL_LIMIT=64).
module tb_spine_egress_buffer;
   import spine_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_dest_addr;
   logic        out_parity;
   logic        fifo_full;
   logic        fifo_empty;
   logic [3:0]  fifo_count;
   logic [15:0] drop_count;
   logic        stall_timeout;

   int n_chk = 0;
   int n_err = 0;

`ifdef SPINE_EGRESS_PARITY_EN
   localparam logic PAR7 = 1'b1;
`else
   localparam logic PAR7 = 1'b0;
`endif

   spine_egress_buffer #(
      .DWIDTH      (16),
      .AWIDTH      (6),
      .DEPTH       (8),
      .STALL_LIMIT (64)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_dest_addr (out_dest_addr),
      .out_parity    (out_parity),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .fifo_count    (fifo_count),
      .drop_count    (drop_count),
      .stall_timeout (stall_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_empty", 32'(fifo_empty), 1);
      check("rst_full", 32'(fifo_full), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_drop", 32'(drop_count), 0);
      check("rst_tmo", 32'(stall_timeout), 0);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      check("rst_par", 32'(out_parity), 0);
      reset = 1'b0;

      // 1: single flit fall-through
      in_data   = 16'hA5C3;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_valid", 32'(out_valid), 1);
      check("t1_data", 32'(out_data), 32'hA5C3);
      check("t1_dest", 32'(out_dest_addr), 32'h29);
      check("t1_state", 32'(dut.state), 32'(SEND));
      tick();
      check("t1_empty", 32'(fifo_empty), 1);
      check("t1_ovalid", 32'(out_valid), 0);
      check("t1_idle", 32'(dut.state), 32'(IDLE));

      // 2: overfill by two with no ready
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 16'h1000 + 16'(i);
         tick();
      end
      in_valid = 1'b0;
      check("t2_full", 32'(fifo_full), 1);
      check("t2_count", 32'(fifo_count), 8);
      check("t2_drop", 32'(drop_count), 2);
      check("t2_hold", 32'(out_data), 32'h1000);
      check("t2_state", 32'(dut.state), 32'(STALL));
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("t2_order", 32'(out_data), 32'h1000 + i);
         tick();
      end
      check("t2_empty", 32'(fifo_empty), 1);

      // 3: push while full with pop, pointers wrap
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 16'h2000 + 16'(i);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 16'h2100 + 16'(i);
         check("t3_head", 32'(out_data), 32'h2000 + i);
         tick();
         check("t3_count", 32'(fifo_count), 8);
         check("t3_drop", 32'(drop_count), 2);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("t3_order", 32'(out_data),
               (i < 4) ? 32'h2004 + i : 32'h2100 + (i - 4));
         tick();
      end
      check("t3_empty", 32'(fifo_empty), 1);

      // 4: stall watchdog
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h3000;
      tick();
      in_valid = 1'b0;
      check("t4_send", 32'(dut.state), 32'(SEND));
      tick();
      check("t4_stall", 32'(dut.state), 32'(STALL));
      repeat (63) tick();
      check("t4_tmo63", 32'(stall_timeout), 0);
      tick();
      check("t4_tmo64", 32'(stall_timeout), 1);
      tick();
      check("t4_tmosat", 32'(stall_timeout), 1);
      check("t4_state", 32'(dut.state), 32'(STALL));
      out_ready = 1'b1;
      tick();
      check("t4_clr", 32'(stall_timeout), 0);
      check("t4_idle", 32'(dut.state), 32'(IDLE));

      // 5: drop counter saturation, then reset mid-burst
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 16'h4000 + 16'(i);
         tick();
      end
      repeat (65540) tick();
      check("t5_sat", 32'(drop_count), 32'hFFFF);
      check("t5_count", 32'(fifo_count), 8);
      out_ready = 1'b1;
      reset     = 1'b1;
      tick();
      check("t5_rcount", 32'(fifo_count), 0);
      check("t5_rvalid", 32'(out_valid), 0);
      check("t5_rdrop", 32'(drop_count), 0);
      check("t5_rtmo", 32'(stall_timeout), 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      tick();
      check("t5_idle", 32'(fifo_empty), 1);

      // 6: parity
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0007;
      tick();
      in_valid = 1'b0;
      check("t6_data", 32'(out_data), 32'h0007);
      check("t6_par", 32'(out_parity), 32'(PAR7));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
